fv_bank_req_arbiter: RTL and testbench
======================================

# fv_bank_req_arbiter

Per-bank request arbiter that sits in front of a big feature-value SRAM bank controller. It shares the bank's single `req_pkt` port between `NUM_PE` Edge-PE read requesters and one write-back source (accumulation or vertex buffer). It sequences whole transactions: a read occupies the bank until the bank returns end-of-stream, and a write occupies it for a contiguous burst. It blocks new grants while the bank is in iteration-stream mode.

## Interface
- `NUM_PE`, default `` `Num_Edge_PE `` (4): number of read requesters.
- `NODE_W`, default `` $clog2(`Max_Node_id) ``: node-id width.
- `DATA_W`, default `` `FV_bandwidth ``: write-beat width.
- `WB_MAX_CONSEC`, default 2: maximum number of back-to-back write bursts while a read is pending.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stream_mode`  in  1  bank is in replay-iteration stream mode (`Cur_Update_Iter[0]`); no new grants while high.
- `pe_req_valid`  in  NUM_PE  read request per PE.
- `pe_req_node_id`  in  NUM_PE×NODE_W  node id per PE.
- `pe_req_ready`  out  NUM_PE  one-hot grant; a handshake is `valid & ready`.
- `wb_valid`  in  1  write-back beat available.
- `wb_node_id`  in  NODE_W  burst node id; sampled on the first beat only.
- `wb_data`  in  DATA_W  beat data.
- `wb_eos`  in  1  last beat of the burst.
- `wb_ready`  out  1  beat accepted.
- `rd_eos`  in  1  bank read stream finished (bank `EdgePE_rd_out.eos`).
- `req_pkt`  out  `Req2Output_SRAM_Bank`  registered request to the bank controller.
- `busy`  out  1  state ≠ IDLE.
- `wb_underrun_err`  out  1  sticky; set when `wb_valid` drops mid-burst.

## Operation
- FSM states:
  - **IDLE**: no transaction in progress.
  - **RD_WAIT**: a read has been issued and the bank is streaming it.
  - **WB_BURST**: a write burst is in progress.
- IDLE with `stream_mode`=1: no grants; all `ready` outputs are 0.
- IDLE with `stream_mode`=0: pick one source, using the priority rules below.
- Priority:
  - Write-back wins if `wb_valid`, unless `wb_consec` == WB_MAX_CONSEC and some `pe_req_valid` is high. In that case a read wins.
  - Reads are granted round-robin. `rr_ptr` points to the highest-priority PE and advances to grantee+1 (mod NUM_PE) on each read grant.
  - `wb_consec` increments on each write grant, saturating at WB_MAX_CONSEC. It clears on a read grant, or on any IDLE cycle with no read pending.
- Read grant at cycle t:
  - `pe_req_ready[g]`=1 combinationally at t.
  - At t+1, `req_pkt` = {valid=1, rd_wr=0, Node_id=node, PE_tag=g, wr_eos=0, data=0}. State goes to RD_WAIT.
- RD_WAIT:
  - `req_pkt.valid`=0.
  - `Node_id` and `PE_tag` are held at the issued values, because the bank re-reads `Node_id` on every streaming cycle.
  - `rd_eos`=1 returns the FSM to IDLE.
- Write grant:
  - `wb_ready`=1 at t, when the first beat is taken.
  - At t+1, `req_pkt` = {valid=1, rd_wr=1, Node_id=wb_node_id, data=wb_data, wr_eos=wb_eos}.
  - If `wb_eos` is 0, go to WB_BURST. A first beat with `wb_eos`=1 is a single-beat burst and returns to IDLE.
- WB_BURST:
  - `wb_ready`=1 every cycle.
  - Each accepted beat is registered onto `req_pkt` the next cycle. `Node_id` is held from the first beat.
  - A beat with `wb_eos` returns the FSM to IDLE after it is registered.
  - The bank consumes one beat per cycle unconditionally. If `wb_valid`=0 in WB_BURST:
    - set `wb_underrun_err`;
    - drive data=0, valid=1, wr_eos=0 for that beat;
    - stay in WB_BURST.
- `stream_mode` rising during RD_WAIT or WB_BURST does not abort the transaction. It only blocks the next grant.
- Node-id width is NODE_W. It is passed through unmodified; the bank forms the line address itself.

## Timing
- Reset: state=IDLE, `rr_ptr`=0, `wb_consec`=0. All outputs are 0, including all `req_pkt` fields, `wb_underrun_err`, `busy`, and the ready outputs.
- Reset mid-transaction: the FSM goes to IDLE immediately and `req_pkt.valid` is 0 on the next cycle. The bank controller is reset by the same reset.
- `req_pkt` is fully registered: grant-to-bank latency is 1 cycle.
- `ready` outputs are combinational from state, the valid inputs, `stream_mode`, `rr_ptr` and `wb_consec`. There is no input-to-`req_pkt` combinational path.
- `rd_eos` at cycle t gives IDLE at t+1. A new grant is possible at t+1, and the bank sees the next `req_pkt` at t+2.
- Last write beat registered at t: a new grant is possible at t+1. At most one `ready` output is high in any cycle.
- Back-to-back reads from the same PE are permitted; round-robin applies only among simultaneous requesters.

## Structure
- Shared package `sys_defs` holds `Req2Output_SRAM_Bank`, `` `Num_Edge_PE ``, `` `FV_bandwidth ``, `` `Max_Node_id `` and the state enum `fv_arb_state_t`.
- Sub-module `rr_arbiter #(N)`: request vector plus pointer in, one-hot grant plus grant index out. It is purely combinational; the pointer register stays in the parent.
- Expected size is roughly 200 lines of RTL.

## Test plan
- **Single read:** PE2 requests node 40 → `pe_req_ready`=4'b0100. Next cycle `req_pkt` = {1,rd,40,tag 2}. `Node_id` is held at 40 until `rd_eos`, then `busy`=0.
- **Round-robin:** all four PEs request continuously → grant order 0,1,2,3,0, each grant starting the cycle after `rd_eos`.
- **Write preference and starvation bound:** `wb_valid` held high with 1-beat bursts, and PE1 pending → order WB, WB, PE1, WB, WB, PE1 (WB_MAX_CONSEC=2).
- **8-beat burst:** data 0..7 with `wb_eos` on beat 7 → `req_pkt.data` = 0..7 on 8 consecutive cycles, `Node_id` constant, `wr_eos` only on the last beat, then IDLE.
- **Stream block:** `stream_mode`=1 with requests pending → no `ready` for its duration. First grant comes the cycle `stream_mode` falls; an in-flight read finishes normally.
- **Underrun and reset:** `wb_valid` drops at beat 3 → `wb_underrun_err`=1 and a data=0 beat is issued. Then `reset` asserted mid-burst → all outputs 0 next cycle and the error flag cleared.

Source files
------------

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared sizing, FSM state and bank request packet for the feature-value bank arbiter
package sys_defs;
    localparam int NUM_EDGE_PE  = 4;
    localparam int FV_BANDWIDTH = 32;
    localparam int MAX_NODE_ID  = 1024;
    localparam int FV_NODE_W    = $clog2(MAX_NODE_ID);
    localparam int PE_TAG_W     = (NUM_EDGE_PE > 1) ? $clog2(NUM_EDGE_PE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_WB_BURST = 2'd2
    } fv_arb_state_t;

    typedef struct packed {
        logic                    valid;
        logic                    rd_wr;
        logic [FV_NODE_W-1:0]    Node_id;
        logic [PE_TAG_W-1:0]     PE_tag;
        logic                    wr_eos;
        logic [FV_BANDWIDTH-1:0] data;
    } Req2Output_SRAM_Bank;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] k;

    // Walk offsets from farthest to nearest so the requester closest to ptr is the last write.
    always_comb begin
        gnt = '0;
        idx = '0;
        k   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % N);
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end
endmodule

// File: rtl/fv_bank_req_arbiter.sv
// rtl/fv_bank_req_arbiter.sv - shares one SRAM bank request port between Edge-PE reads and a write-back source
module fv_bank_req_arbiter
    import sys_defs::*;
#(
    parameter int NUM_PE        = NUM_EDGE_PE,
    parameter int NODE_W        = $clog2(MAX_NODE_ID),
    parameter int DATA_W        = FV_BANDWIDTH,
    parameter int WB_MAX_CONSEC = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stream_mode,
    input  logic [NUM_PE-1:0]        pe_req_valid,
    input  logic [NUM_PE*NODE_W-1:0] pe_req_node_id,
    output logic [NUM_PE-1:0]        pe_req_ready,
    input  logic                     wb_valid,
    input  logic [NODE_W-1:0]        wb_node_id,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     wb_eos,
    output logic                     wb_ready,
    input  logic                     rd_eos,
    output Req2Output_SRAM_Bank      req_pkt,
    output logic                     busy,
    output logic                     wb_underrun_err
);
    localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int CW    = $clog2(WB_MAX_CONSEC + 1);

    fv_arb_state_t       state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       wb_consec_q, wb_consec_d;
    Req2Output_SRAM_Bank pkt_q, pkt_d;
    logic                err_q, err_d;

    logic [NUM_PE-1:0]   rr_gnt;
    logic [PTR_W-1:0]    rr_idx;
    logic                rd_pending, can_grant, wb_starving, grant_wb, grant_rd;

    rr_arbiter #(.N(NUM_PE)) u_rr (
        .req (pe_req_valid),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    always_comb begin
        rd_pending  = |pe_req_valid;
        can_grant   = !reset && (state_q == ST_IDLE) && !stream_mode;
        wb_starving = (wb_consec_q == CW'(WB_MAX_CONSEC)) && rd_pending;
        grant_wb    = can_grant && wb_valid && !wb_starving;
        grant_rd    = can_grant && rd_pending && !grant_wb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_rd) begin
                    state_d = ST_RD_WAIT;
                end else if (grant_wb && !wb_eos) begin
                    state_d = ST_WB_BURST;
                end
            end
            ST_RD_WAIT:  if (rd_eos) state_d = ST_IDLE;
            ST_WB_BURST: if (wb_valid && wb_eos) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pe_req_ready    = grant_rd ? rr_gnt : '0;
        wb_ready        = grant_wb || (!reset && (state_q == ST_WB_BURST));
        busy            = (state_q != ST_IDLE);
        req_pkt         = pkt_q;
        wb_underrun_err = err_q;
    end

    // Node_id and PE_tag stay on the packet after issue: the bank re-reads them while streaming.
    always_comb begin
        pkt_d        = pkt_q;
        pkt_d.valid  = 1'b0;
        pkt_d.wr_eos = 1'b0;
        rr_ptr_d     = rr_ptr_q;
        wb_consec_d  = wb_consec_q;
        err_d        = err_q;
        if (grant_rd) begin
            pkt_d.valid   = 1'b1;
            pkt_d.rd_wr   = 1'b0;
            pkt_d.Node_id = pe_req_node_id[rr_idx*NODE_W +: NODE_W];
            pkt_d.PE_tag  = rr_idx;
            pkt_d.data    = '0;
            rr_ptr_d      = (rr_idx == PTR_W'(NUM_PE - 1)) ? '0 : rr_idx + 1'b1;
            wb_consec_d   = '0;
        end else if (grant_wb) begin
            pkt_d.valid   = 1'b1;
            pkt_d.rd_wr   = 1'b1;
            pkt_d.Node_id = wb_node_id;
            pkt_d.PE_tag  = '0;
            pkt_d.data    = wb_data;
            pkt_d.wr_eos  = wb_eos;
            if (wb_consec_q != CW'(WB_MAX_CONSEC)) begin
                wb_consec_d = wb_consec_q + 1'b1;
            end
        end else if ((state_q == ST_IDLE) && !rd_pending) begin
            wb_consec_d = '0;
        end
        // The bank takes a beat every cycle, so a missing beat is sent as a zero filler.
        if (state_q == ST_WB_BURST) begin
            pkt_d.valid  = 1'b1;
            pkt_d.rd_wr  = 1'b1;
            pkt_d.data   = wb_valid ? wb_data : '0;
            pkt_d.wr_eos = wb_valid && wb_eos;
            if (!wb_valid) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            wb_consec_q <= '0;
            pkt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wb_consec_q <= wb_consec_d;
            pkt_q       <= pkt_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_fv_bank_req_arbiter.sv
// tb/tb_fv_bank_req_arbiter.sv - self-checking bench for fv_bank_req_arbiter
module tb_fv_bank_req_arbiter;
    import sys_defs::*;

    localparam int NPE  = NUM_EDGE_PE;
    localparam int NW   = FV_NODE_W;
    localparam int DW   = FV_BANDWIDTH;
    localparam int MAXC = 2;

    logic                  clk = 1'b0;
    logic                  reset, stream_mode, wb_valid, wb_eos, wb_ready, rd_eos, busy, wb_underrun_err;
    logic [NPE-1:0]        pe_req_valid, pe_req_ready;
    logic [NPE*NW-1:0]     pe_req_node_id;
    logic [NW-1:0]         wb_node_id;
    logic [DW-1:0]         wb_data;
    Req2Output_SRAM_Bank   req_pkt;

    always #5 clk = ~clk;

    fv_bank_req_arbiter #(.NUM_PE(NPE), .NODE_W(NW), .DATA_W(DW), .WB_MAX_CONSEC(MAXC)) dut (
        .clk(clk), .reset(reset), .stream_mode(stream_mode),
        .pe_req_valid(pe_req_valid), .pe_req_node_id(pe_req_node_id), .pe_req_ready(pe_req_ready),
        .wb_valid(wb_valid), .wb_node_id(wb_node_id), .wb_data(wb_data), .wb_eos(wb_eos),
        .wb_ready(wb_ready), .rd_eos(rd_eos), .req_pkt(req_pkt), .busy(busy),
        .wb_underrun_err(wb_underrun_err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_node(input int pe, input logic [NW-1:0] v);
        pe_req_node_id[pe*NW +: NW] = v;
    endtask

    // Transaction-level reference: which transaction owns the bank and what the next packet must be.
    int            m_mode;   // 0 free, 1 read outstanding, 2 write burst
    int            m_ptr, m_consec, m_tag, g_rd;
    bit            m_err, g_wb, e_valid, e_rdwr, e_eos, was_reset;
    logic [NW-1:0] m_node;
    logic [DW-1:0] e_data;

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_consec = 0; m_tag = 0; m_err = 1'b0; m_node = '0;
        e_valid = 1'b0; e_rdwr = 1'b0; e_eos = 1'b0; e_data = '0;
    endtask

    task automatic model_grant();
        g_wb = 1'b0;
        g_rd = -1;
        if (!reset && m_mode == 0 && !stream_mode) begin
            if (wb_valid && !(m_consec == MAXC && pe_req_valid != 0)) g_wb = 1'b1;
            else
                for (int i = 0; i < NPE; i++)
                    if (g_rd < 0 && pe_req_valid[(m_ptr + i) % NPE]) g_rd = (m_ptr + i) % NPE;
        end
    endtask

    task automatic model_step();
        was_reset = reset;
        e_valid = 1'b0;
        e_eos   = 1'b0;
        if (reset) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (g_wb) begin
                m_consec = (m_consec < MAXC) ? m_consec + 1 : MAXC;
                m_node = wb_node_id;
                e_valid = 1'b1; e_rdwr = 1'b1; e_data = wb_data; e_eos = wb_eos;
                m_mode = wb_eos ? 0 : 2;
            end else if (g_rd >= 0) begin
                m_consec = 0;
                m_ptr = (g_rd + 1) % NPE;
                m_node = pe_req_node_id[g_rd*NW +: NW];
                m_tag = g_rd;
                e_valid = 1'b1; e_rdwr = 1'b0; e_data = '0;
                m_mode = 1;
            end else if (pe_req_valid == 0) begin
                m_consec = 0;
            end
        end else if (m_mode == 1) begin
            if (rd_eos) m_mode = 0;
        end else begin
            e_valid = 1'b1; e_rdwr = 1'b1;
            e_data = wb_valid ? wb_data : '0;
            e_eos = wb_valid && wb_eos;
            if (!wb_valid) m_err = 1'b1;
            if (wb_valid && wb_eos) m_mode = 0;
        end
    endtask

    task automatic tick();
        logic [NPE-1:0] xr;
        #1;
        model_grant();
        xr = (g_rd >= 0) ? NPE'(1 << g_rd) : '0;
        chk("rnd pe_ready", pe_req_ready, xr);
        chk("rnd wb_ready", wb_ready, g_wb || (!reset && m_mode == 2));
        @(posedge clk); #1;
        model_step();
        if (was_reset) begin
            chk("rnd reset pkt", req_pkt, '0);
        end else begin
            chk("rnd busy", busy, m_mode != 0);
            chk("rnd err", wb_underrun_err, m_err);
            chk("rnd valid", req_pkt.valid, e_valid);
            if (e_valid) begin
                chk("rnd rd_wr", req_pkt.rd_wr, e_rdwr);
                chk("rnd node", req_pkt.Node_id, m_node);
                chk("rnd data", req_pkt.data, e_data);
                chk("rnd wr_eos", req_pkt.wr_eos, e_eos);
                if (!e_rdwr) chk("rnd tag", req_pkt.PE_tag, m_tag);
            end else if (m_mode == 1) begin
                chk("rnd held node", req_pkt.Node_id, m_node);
                chk("rnd held tag", req_pkt.PE_tag, m_tag);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; stream_mode = 1'b0; pe_req_valid = '0; pe_req_node_id = '0;
        wb_valid = 1'b0; wb_node_id = '0; wb_data = '0; wb_eos = 1'b0; rd_eos = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       stream;
        logic [3:0] pe_v;
        logic       wb_v, wb_e, rd_e;
        logic [3:0] x_pe_rdy;
        logic       x_wb_rdy, x_valid, x_rdwr, x_busy;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state, then the vector table from a freshly reset arbiter.
        do_reset();
        chk("reset pkt", req_pkt, '0);
        chk("reset busy", busy, 1'b0);
        chk("reset err", wb_underrun_err, 1'b0);
        chk("reset ready", {pe_req_ready, wb_ready}, '0);
        for (int i = 0; i < NPE; i++) set_node(i, NW'(10 + i));
        wb_node_id = NW'(99);
        wb_data = 32'h5A5A_0001;
        for (int i = 0; i < 17; i++) begin
            stream_mode = tbl[i].stream; pe_req_valid = tbl[i].pe_v;
            wb_valid = tbl[i].wb_v; wb_eos = tbl[i].wb_e; rd_eos = tbl[i].rd_e;
            #1;
            chk($sformatf("tbl%0d pe_ready", i), pe_req_ready, tbl[i].x_pe_rdy);
            chk($sformatf("tbl%0d wb_ready", i), wb_ready, tbl[i].x_wb_rdy);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d valid", i), req_pkt.valid, tbl[i].x_valid);
            if (tbl[i].x_valid) chk($sformatf("tbl%0d rd_wr", i), req_pkt.rd_wr, tbl[i].x_rdwr);
            chk($sformatf("tbl%0d busy", i), busy, tbl[i].x_busy);
        end

        // Single read: node id held through the stream until rd_eos.
        do_reset();
        set_node(2, NW'(40));
        pe_req_valid = 4'b0100;
        #1; chk("rd ready", pe_req_ready, 4'b0100);
        @(posedge clk); #1;
        pe_req_valid = '0;
        set_node(2, NW'(7));
        chk("rd valid", req_pkt.valid, 1'b1);
        chk("rd rd_wr", req_pkt.rd_wr, 1'b0);
        chk("rd node", req_pkt.Node_id, 40);
        chk("rd tag", req_pkt.PE_tag, 2);
        chk("rd data", req_pkt.data, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rd hold node", req_pkt.Node_id, 40);
            chk("rd hold valid", req_pkt.valid, 1'b0);
            chk("rd hold busy", busy, 1'b1);
        end
        rd_eos = 1'b1;
        @(posedge clk); #1;
        rd_eos = 1'b0;
        chk("rd done busy", busy, 1'b0);

        // 8-beat burst: later node ids must be ignored.
        do_reset();
        wb_valid = 1'b1; wb_node_id = NW'(77); wb_data = '0; wb_eos = 1'b0;
        #1; chk("burst first ready", wb_ready, 1'b1);
        for (int b = 0; b < 8; b++) begin
            wb_data = DW'(b);
            wb_eos = (b == 7);
            if (b > 0) wb_node_id = NW'(300 + b);
            @(posedge clk); #1;
            chk("burst valid", req_pkt.valid, 1'b1);
            chk("burst data", req_pkt.data, b);
            chk("burst node", req_pkt.Node_id, 77);
            chk("burst wr_eos", req_pkt.wr_eos, b == 7);
        end
        wb_valid = 1'b0; wb_eos = 1'b0;
        chk("burst idle", busy, 1'b0);
        @(posedge clk); #1;
        chk("burst quiet", req_pkt.valid, 1'b0);

        // Stream mode blocks new grants but lets the in-flight read finish.
        do_reset();
        set_node(0, NW'(5));
        pe_req_valid = 4'b0001;
        @(posedge clk); #1;
        stream_mode = 1'b1; pe_req_valid = 4'b1111; wb_valid = 1'b1; wb_eos = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rd_eos = (c == 2);
            #1; chk("stream no grant", {pe_req_ready, wb_ready}, '0);
            @(posedge clk); #1;
            chk("stream busy", busy, c < 2);
        end
        stream_mode = 1'b0; wb_valid = 1'b0; rd_eos = 1'b0;
        #1; chk("stream release grant", pe_req_ready, 4'b0010);
        @(posedge clk); #1;
        pe_req_valid = '0;
        chk("stream release tag", req_pkt.PE_tag, 1);
        chk("stream release valid", req_pkt.valid, 1'b1);

        // Underrun at beat 3, then reset mid-burst.
        do_reset();
        wb_eos = 1'b0; wb_node_id = NW'(9);
        for (int b = 0; b < 5; b++) begin
            wb_valid = (b != 3);
            wb_data = DW'(100 + b);
            @(posedge clk); #1;
            if (b == 3) begin
                chk("underrun err", wb_underrun_err, 1'b1);
                chk("underrun data", req_pkt.data, 0);
                chk("underrun valid", req_pkt.valid, 1'b1);
                chk("underrun eos", req_pkt.wr_eos, 1'b0);
                chk("underrun busy", busy, 1'b1);
            end
        end
        chk("underrun sticky", wb_underrun_err, 1'b1);
        chk("underrun next data", req_pkt.data, 104);
        reset = 1'b1; wb_valid = 1'b1;
        #1; chk("midreset ready", {pe_req_ready, wb_ready}, '0);
        @(posedge clk); #1;
        chk("midreset pkt", req_pkt, '0);
        chk("midreset err", wb_underrun_err, 1'b0);
        chk("midreset busy", busy, 1'b0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 99) < 2);
            stream_mode = ($urandom_range(0, 99) < 20);
            pe_req_valid = NPE'($urandom) & NPE'($urandom);
            pe_req_node_id = (NPE*NW)'({$urandom, $urandom});
            wb_valid = ($urandom_range(0, 99) < 70);
            wb_node_id = NW'($urandom);
            wb_data = DW'($urandom);
            wb_eos = ($urandom_range(0, 99) < 30);
            rd_eos = ($urandom_range(0, 99) < 35);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
